// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART transmit arbiter
package uart_pkg;

   localparam int UART_DATA_W    = 8;
   localparam int GAP_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD,
      WAIT_IDLE
   } arb_state_e;

   function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selection starting at rr_ptr with wrap-around
module rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_valid,
   input  logic [W-1:0] rr_ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W:0] pos;

   // scan offsets from farthest to nearest so the first valid slot at or after rr_ptr wins
   always_comb begin
      idx = '0;
      pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr} + (W + 1)'(k);
         pos = (pos >= (W + 1)'(N)) ? pos - (W + 1)'(N) : pos;
         if (req_valid[pos[W-1:0]]) idx = pos[W-1:0];
      end
   end

   assign any   = |req_valid;
   assign grant = any ? N'(1) << idx : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte producers
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             tx_idle,
   output logic [UART_DATA_W-1:0]           dataout,
   output logic                             wrsig,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(GAP_CYCLES + 1);

   arb_state_e             state_q, state_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]          grant_id_q, grant_id_d;
   logic [UART_DATA_W-1:0] dataout_q, dataout_d;
   logic [CW-1:0]          gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0]     pick_grant;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   logic                   accept;

   rr_picker #(
      .N (NUM_REQ),
      .W (IW)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any       (pick_any)
   );

   // next-state: accept in IDLE, one-cycle issue, fixed gap, then wait for the transmitter
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      dataout_d  = dataout_q;
      gap_cnt_d  = gap_cnt_q;
      accept     = (state_q == IDLE) && pick_any && tx_idle;
      case (state_q)
         IDLE: if (accept) begin
            dataout_d  = req_data[UART_DATA_W*pick_idx +: UART_DATA_W];
            grant_id_d = pick_idx;
            rr_ptr_d   = IW'(wrap_inc(32'(pick_idx), NUM_REQ));
            state_d    = ISSUE;
         end
         ISSUE: begin
            gap_cnt_d = '0;
            state_d   = HOLD;
         end
         HOLD: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            state_d   = (gap_cnt_q == CW'(GAP_CYCLES - 1)) ? WAIT_IDLE : HOLD;
         end
         WAIT_IDLE: state_d = tx_idle ? IDLE : WAIT_IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, pointer, latched byte and gap counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         dataout_q  <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         dataout_q  <= dataout_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign req_ready = accept ? pick_grant : '0;
   assign wrsig     = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign dataout   = dataout_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, pacing and reset behaviour
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tx_idle_man = 1'b1;
   logic         use_model = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0] req_ready;
   logic         tx_idle;
   logic         wrsig;
   logic         busy;
   logic [7:0]   dataout;
   logic [1:0]   grant_id;

   int tests = 0;
   int fails = 0;
   int mcnt  = 0;
   int n     = 0;
   int cyc   = 0;
   int bad   = 0;
   int at  [5];
   logic [7:0] got [5];
   logic [7:0] exp2 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_idle   (tx_idle),
      .dataout   (dataout),
      .wrsig     (wrsig),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // transmitter model: busy for 20 cycles after each send command
   always @(posedge clk) begin
      if (wrsig) mcnt <= 20;
      else if (mcnt != 0) mcnt <= mcnt - 1;
   end

   assign tx_idle = use_model ? (mcnt == 0) : tx_idle_man;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && busy; i++) tick();
      chk(tag, 32'(busy), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // reset values
      tick();
      tick();
      chk("rst_dataout", 32'(dataout), 0);
      chk("rst_wrsig", 32'(wrsig), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      rst = 1'b0;
      // single requester 2
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      #1;
      chk("t1_wrsig", 32'(wrsig), 1);
      chk("t1_dataout", 32'(dataout), 32'hA5);
      chk("t1_grant", 32'(grant_id), 2);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready_off", 32'(req_ready), 0);
      tick();
      chk("t1_wrsig_one", 32'(wrsig), 0);
      // rr_ptr is 3: requesters 0 and 3 together
      wait_idle("t4_idle_a");
      req_data[7:0] = 8'h40;
      req_data[31:24] = 8'h43;
      req_valid = 4'b1001;
      #1;
      chk("t4_ready3", 32'(req_ready), 32'h8);
      tick();
      chk("t4_grant3", 32'(grant_id), 3);
      chk("t4_data3", 32'(dataout), 32'h43);
      wait_idle("t4_idle_b");
      #1;
      chk("t4_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("t4_grant0", 32'(grant_id), 0);
      chk("t4_data0", 32'(dataout), 32'h40);
      // data changed after accept is ignored
      wait_idle("t5_idle");
      req_data[15:8] = 8'h55;
      req_valid = 4'b0010;
      #1;
      chk("t5_ready", 32'(req_ready), 32'h2);
      tick();
      req_data[15:8] = 8'h66;
      req_valid = '0;
      #1;
      chk("t5_wrsig", 32'(wrsig), 1);
      chk("t5_data", 32'(dataout), 32'h55);
      tick();
      tick();
      tick();
      chk("t5_hold", 32'(dataout), 32'h55);
      // transmitter busy blocks acceptance
      wait_idle("t3_idle");
      tx_idle_man = 1'b0;
      req_valid = 4'b0001;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (req_ready != 0 || wrsig) bad++;
         tick();
      end
      chk("t3_blocked", 32'(bad), 0);
      tx_idle_man = 1'b1;
      #1;
      chk("t3_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("t3_wrsig", 32'(wrsig), 1);
      chk("t3_grant", 32'(grant_id), 0);
      // all requesters valid with transmitter model
      wait_idle("t2_idle");
      do_reset();
      use_model = 1'b1;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b1111;
      n = 0;
      cyc = 0;
      while (n < 5 && cyc < 300) begin
         if (wrsig) begin
            got[n] = dataout;
            at[n] = cyc;
            n++;
         end
         tick();
         cyc++;
      end
      req_valid = '0;
      chk("t2_count", 32'(n), 5);
      for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), 32'(got[k]), 32'(exp2[k]));
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("t2_min_gap%0d", k), 32'((at[k] - at[k-1]) >= GAP + 3), 1);
         chk($sformatf("t2_spacing%0d", k), 32'(at[k] - at[k-1]), 23);
      end
      use_model = 1'b0;
      // reset in HOLD
      wait_idle("t6_idle_a");
      do_reset();
      req_data[15:8] = 8'h21;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t6h_busy", 32'(busy), 0);
      chk("t6h_wrsig", 32'(wrsig), 0);
      chk("t6h_data", 32'(dataout), 0);
      chk("t6h_grant", 32'(grant_id), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wrsig) bad++;
      end
      chk("t6h_no_wrsig", 32'(bad), 0);
      // move rr_ptr to 2, then reset in the accept cycle
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      wait_idle("t6_idle_b");
      req_data[7:0] = 8'h30;
      req_data[23:16] = 8'h32;
      req_valid = 4'b0101;
      rst = 1'b1;
      tick();
      chk("t6a_wrsig", 32'(wrsig), 0);
      chk("t6a_busy", 32'(busy), 0);
      chk("t6a_data", 32'(dataout), 0);
      chk("t6a_grant", 32'(grant_id), 0);
      rst = 1'b0;
      #1;
      chk("t6a_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("t6a_wrsig0", 32'(wrsig), 1);
      chk("t6a_data0", 32'(dataout), 32'h30);
      chk("t6a_grant0", 32'(grant_id), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
